// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings (HTRANS/HBURST/HRESP) and one-hot FSM state indices
// for the AHB slave interface and its checker.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int ST_IDLE_IDX   = 0;
    localparam int ST_ACCESS_IDX = 1;
    localparam int ST_ERR1_IDX   = 2;
    localparam int ST_ERR2_IDX   = 3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001 << ST_IDLE_IDX,
        ST_ACCESS = 4'b0001 << ST_ACCESS_IDX,
        ST_ERR1   = 4'b0001 << ST_ERR1_IDX,
        ST_ERR2   = 4'b0001 << ST_ERR2_IDX
    } state_e;

endpackage

// File: rtl/ahb_slave_check.sv
// Address-phase legality check and byte-lane mask generation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results are consumed only when the caller samples a phase.
module ahb_slave_check
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH = 32,
    localparam int NL   = AHB_DATA_WIDTH / 8,
    localparam int OFFW = $clog2(NL)
) (
    input  logic [OFFW-1:0] offs,
    input  logic [2:0]      size,
    input  logic [1:0]      trans,
    input  logic [2:0]      burst,
    input  logic            prev_vld,
    input  logic [2:0]      prev_burst,
    output logic            legal,
    output logic [NL-1:0]   strb
);

    logic oversize;
    logic misalign;
    logic bad_seq;

    always_comb begin
        oversize = int'(size) > OFFW;
        misalign = 1'b0;
        for (int i = 0; i < OFFW; i++) begin
            if (i < int'(size) && offs[i]) misalign = 1'b1;
        end
        // A SEQ must continue a live burst of the same type.
        bad_seq = (trans == HTRANS_SEQ) && !(prev_vld && (prev_burst == burst));
        legal   = !(oversize || misalign || bad_seq);
        strb    = '0;
        for (int i = 0; i < NL; i++) begin
            strb[i] = (i >= int'(offs)) && (i < int'(offs) + (1 << size));
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave bridging one transfer at a time onto a local request bus; AHB_WSTRB_EN adds ahb_strb_in.
// Latency: local request the cycle after the address phase; back-to-back bursts with zero idle cycles.
// Backpressure: HREADYOUT follows other_ready_in; errors answer with a two-cycle ERROR response.
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                        ahb_clk_in,
    input  logic                        ahb_rstn_in,
    input  logic                        ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in,
    input  logic [1:0]                  ahb_trans_in,
    input  logic                        ahb_write_in,
    input  logic [2:0]                  ahb_size_in,
    input  logic [2:0]                  ahb_burst_in,
    input  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in,
    input  logic                        ahb_ready_in,
`ifdef AHB_WSTRB_EN
    input  logic [AHB_DATA_WIDTH/8-1:0] ahb_strb_in,
`endif
    output logic                        ahb_readyout_out,
    output logic                        ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out,
    output logic                        other_valid_out,
    output logic [AHB_ADDR_WIDTH-1:0]   other_addr_out,
    output logic                        other_write_out,
    output logic [2:0]                  other_size_out,
    output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
    output logic [AHB_DATA_WIDTH-1:0]   other_wdata_out,
    output logic [3:0]                  other_beat_out,
    input  logic                        other_ready_in,
    input  logic                        other_error_in,
    input  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in
);

    localparam int NL   = AHB_DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NL);

    state_e                    state;
    state_e                    phase_next;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [2:0]                size_q;
    logic [2:0]                burst_q;
    logic [NL-1:0]             strb_q;
    logic [3:0]                beat_q;
    logic                      prev_vld;

    logic          legal;
    logic [NL-1:0] lane_mask;
    logic          in_access;
    logic          null_wr;
    logic          active;
    logic          done_ok;
    logic          err_hit;
    logic          win;
    logic          sample;

    ahb_slave_check #(.AHB_DATA_WIDTH(AHB_DATA_WIDTH)) u_check (
        .offs       (ahb_addr_in[OFFW-1:0]),
        .size       (ahb_size_in),
        .trans      (ahb_trans_in),
        .burst      (ahb_burst_in),
        .prev_vld   (prev_vld),
        .prev_burst (burst_q),
        .legal      (legal),
        .strb       (lane_mask)
    );

    assign in_access = state[ST_ACCESS_IDX];

`ifdef AHB_WSTRB_EN
    // A write with no enabled lanes finishes locally without a request.
    assign null_wr        = write_q && (ahb_strb_in == '0);
    assign other_strb_out = active ? (write_q ? (strb_q & ahb_strb_in) : strb_q) : '0;
`else
    assign null_wr        = 1'b0;
    assign other_strb_out = active ? strb_q : '0;
`endif

    assign active  = in_access && !null_wr;
    assign done_ok = null_wr || (other_ready_in && !other_error_in);
    assign err_hit = active && other_ready_in && other_error_in;
    // Edges where the bus may hand us a new address phase.
    assign win     = state[ST_IDLE_IDX] || state[ST_ERR2_IDX] || (in_access && done_ok);
    assign sample  = win && ahb_sel_in && ahb_ready_in && ahb_trans_in[1];

    assign phase_next = !sample ? ST_IDLE : (legal ? ST_ACCESS : ST_ERR1);

    assign other_valid_out  = active;
    assign other_addr_out   = active ? addr_q : '0;
    assign other_write_out  = active && write_q;
    assign other_size_out   = active ? size_q : '0;
    assign other_wdata_out  = active ? ahb_wdata_in : '0;
    assign other_beat_out   = active ? beat_q : '0;
    assign ahb_rdata_out    = (active && other_ready_in) ? other_rdata_in : '0;
    assign ahb_readyout_out = win;
    assign ahb_resp_out     = (state[ST_ERR1_IDX] || state[ST_ERR2_IDX]) ? HRESP_ERROR : HRESP_OKAY;

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            burst_q  <= '0;
            strb_q   <= '0;
            beat_q   <= '0;
            prev_vld <= 1'b0;
        end else begin
            if (sample) begin
                addr_q   <= ahb_addr_in;
                write_q  <= ahb_write_in;
                size_q   <= ahb_size_in;
                burst_q  <= ahb_burst_in;
                strb_q   <= lane_mask;
                beat_q   <= (ahb_trans_in == HTRANS_NONSEQ) ? 4'd0 : beat_q + 4'd1;
                prev_vld <= legal;
            end else if ((win && !(ahb_sel_in && ahb_trans_in == HTRANS_BUSY)) || err_hit) begin
                prev_vld <= 1'b0;
            end

            case (state)
                ST_ERR1:   state <= ST_ERR2;
                ST_ACCESS: begin
                    if (err_hit)      state <= ST_ERR1;
                    else if (done_ok) state <= phase_next;
                end
                default:   state <= phase_next;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios plus randomized single transfers
// checked against an arithmetic model of the AHB legality and lane-mask rules.
`timescale 1ns/1ps
module tb_ahb_slave_if;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NL = DW / 8;
    localparam int LW = AW + 1 + 3 + NL + DW + 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sel;
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [DW-1:0] wdata;
    logic          hready;
    logic          readyout;
    logic          resp;
    logic [DW-1:0] rdata;
    logic          ovalid;
    logic [AW-1:0] oaddr;
    logic          owrite;
    logic [2:0]    osize;
    logic [NL-1:0] ostrb;
    logic [DW-1:0] owdata;
    logic [3:0]    obeat;
    logic          oready;
    logic          oerr;
    logic [DW-1:0] ordata;
`ifdef AHB_WSTRB_EN
    logic [NL-1:0] hstrb;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign hready = readyout;

    logic [2:0]    hs_obs;
    logic [LW-1:0] loc_obs;
    assign hs_obs  = {readyout, resp, ovalid};
    assign loc_obs = {oaddr, owrite, osize, ostrb, owdata, obeat};

    ahb_slave_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) dut (
        .ahb_clk_in       (clk),
        .ahb_rstn_in      (rstn),
        .ahb_sel_in       (sel),
        .ahb_addr_in      (addr),
        .ahb_trans_in     (trans),
        .ahb_write_in     (write),
        .ahb_size_in      (size),
        .ahb_burst_in     (burst),
        .ahb_wdata_in     (wdata),
        .ahb_ready_in     (hready),
`ifdef AHB_WSTRB_EN
        .ahb_strb_in      (hstrb),
`endif
        .ahb_readyout_out (readyout),
        .ahb_resp_out     (resp),
        .ahb_rdata_out    (rdata),
        .other_valid_out  (ovalid),
        .other_addr_out   (oaddr),
        .other_write_out  (owrite),
        .other_size_out   (osize),
        .other_strb_out   (ostrb),
        .other_wdata_out  (owdata),
        .other_beat_out   (obeat),
        .other_ready_in   (oready),
        .other_error_in   (oerr),
        .other_rdata_in   (ordata)
    );

    function automatic bit m_legal(input logic [1:0] tr, input logic [AW-1:0] a,
                                   input logic [2:0] sz, input bit burst_live);
        int bytes;
        bytes = 1 << sz;
        if (bytes * 8 > DW) return 1'b0;
        if (a % bytes != 0) return 1'b0;
        if (tr == 2'd3 && !burst_live) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NL-1:0] m_strb(input logic [AW-1:0] a, input logic [2:0] sz);
        int bytes;
        bytes = 1 << sz;
        return NL'(((1 << bytes) - 1) << (a % NL));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [AW-1:0] a, input logic w,
                              input logic [2:0] sz, input logic [2:0] bu);
        sel = 1'b1; trans = tr; addr = a; write = w; size = sz; burst = bu;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sel = 1'b0; trans = HTRANS_IDLE; addr = '0; write = 1'b0;
        size = 3'd0; burst = HBURST_SINGLE; wdata = '0; oready = 1'b0; oerr = 1'b0; ordata = '0;
`ifdef AHB_WSTRB_EN
        hstrb = '1;
`endif
        #12;
        n_checks++;
        if (hs_obs !== 3'b100) $display("FAIL reset_hs: got %b expected 100", hs_obs);
        else n_pass++;
        n_checks++;
        if (loc_obs !== '0 || rdata !== '0)
            $display("FAIL reset_outputs: got loc=%h rdata=%h expected 0", loc_obs, rdata);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_write();
        tick(); addr_phase(HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2, HBURST_SINGLE); oready = 1'b0;
        tick(); trans = HTRANS_IDLE; wdata = 32'hDEADBEEF;
        for (int w = 0; w < 3; w++) begin
            if (w > 0) tick();
            oready = (w == 2);
            @(negedge clk);
            n_checks++;
            if (loc_obs !== {32'h10, 1'b1, 3'd2, 4'hF, 32'hDEADBEEF, 4'd0})
                $display("FAIL wr_local[%0d]: got %h expected addr10 wr sz2 strbF DEADBEEF beat0", w, loc_obs);
            else n_pass++;
            n_checks++;
            if (hs_obs !== {w == 2, 1'b0, 1'b1})
                $display("FAIL wr_wait[%0d]: got %b expected %b", w, hs_obs, {w == 2, 1'b0, 1'b1});
            else n_pass++;
        end
        tick(); oready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b100 || loc_obs !== '0)
            $display("FAIL wr_idle: got hs=%b loc=%h expected 100/0", hs_obs, loc_obs);
        else n_pass++;
    endtask

    task automatic test_incr4();
        wdata = '0;
        tick(); addr_phase(HTRANS_NONSEQ, 32'h20, 1'b0, 3'd2, HBURST_INCR4); oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) addr_phase(HTRANS_SEQ, AW'(32'h20 + 4 * (i + 1)), 1'b0, 3'd2, HBURST_INCR4);
            else trans = HTRANS_IDLE;
            ordata = $urandom;
            @(negedge clk);
            n_checks++;
            if (loc_obs !== {AW'(32'h20 + 4 * i), 1'b0, 3'd2, 4'hF, 32'h0, 4'(i)})
                $display("FAIL incr4_beat[%0d]: got %h expected addr %h beat %0d", i, loc_obs,
                         32'h20 + 4 * i, i);
            else n_pass++;
            n_checks++;
            if (hs_obs !== 3'b101 || rdata !== ordata)
                $display("FAIL incr4_rd[%0d]: got hs=%b rdata=%h expected 101 %h", i, hs_obs, rdata, ordata);
            else n_pass++;
        end
        tick(); oready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b100) $display("FAIL incr4_end: got %b expected 100", hs_obs);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        tick(); addr_phase(HTRANS_NONSEQ, 32'h3, 1'b0, 3'd1, HBURST_SINGLE);
        tick(); trans = HTRANS_IDLE;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b010 || loc_obs !== '0)
            $display("FAIL misalign_err1: got hs=%b loc=%h expected 010/0", hs_obs, loc_obs);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b110) $display("FAIL misalign_err2: got %b expected 110", hs_obs);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b100) $display("FAIL misalign_idle: got %b expected 100", hs_obs);
        else n_pass++;
    endtask

    task automatic test_slave_error();
        tick(); addr_phase(HTRANS_NONSEQ, 32'h40, 1'b1, 3'd2, HBURST_SINGLE); wdata = $urandom;
        tick(); trans = HTRANS_IDLE; oready = 1'b1; oerr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b001) $display("FAIL slverr_access: got %b expected 001", hs_obs);
        else n_pass++;
        tick(); oready = 1'b0; oerr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b010) $display("FAIL slverr_err1: got %b expected 010", hs_obs);
        else n_pass++;
        tick(); addr_phase(HTRANS_NONSEQ, 32'h50, 1'b0, 3'd2, HBURST_SINGLE);
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b110) $display("FAIL slverr_err2: got %b expected 110", hs_obs);
        else n_pass++;
        tick(); trans = HTRANS_IDLE; oready = 1'b1; ordata = $urandom;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b101 || oaddr !== 32'h50 || rdata !== ordata)
            $display("FAIL slverr_next: got hs=%b addr=%h rdata=%h expected 101 50 %h",
                     hs_obs, oaddr, rdata, ordata);
        else n_pass++;
        tick(); oready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        tick(); addr_phase(HTRANS_NONSEQ, 32'h60, 1'b1, 3'd2, HBURST_INCR);
        tick(); trans = HTRANS_IDLE; oready = 1'b0; ordata = $urandom;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b001) $display("FAIL rstmid_access: got %b expected 001", hs_obs);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (hs_obs !== 3'b100 || loc_obs !== '0 || rdata !== '0)
            $display("FAIL rstmid_outputs: got hs=%b loc=%h rdata=%h expected 100/0/0", hs_obs, loc_obs, rdata);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        // Reset wipes burst history, so a lone SEQ is illegal.
        tick(); addr_phase(HTRANS_SEQ, 32'h64, 1'b1, 3'd2, HBURST_INCR);
        tick(); trans = HTRANS_IDLE;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b010) $display("FAIL seq_after_reset: got %b expected 010", hs_obs);
        else n_pass++;
        tick(); tick();
    endtask

    task automatic test_random();
        logic [1:0]    tr;
        logic [AW-1:0] a;
        logic [2:0]    sz;
        logic          w;
        logic [DW-1:0] wd;
        int            waits;
        bit            err;
        bit            lgl;
        for (int n = 0; n < 40; n++) begin
            tr = ($urandom_range(0, 7) == 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
            sz = 3'($urandom_range(0, 3));
            a  = AW'($urandom & 32'hFFFF);
            if ($urandom_range(0, 2) != 0) a = a - (a % (1 << sz));
            w     = 1'($urandom_range(0, 1));
            wd    = $urandom;
            waits = $urandom_range(0, 3);
            err   = ($urandom_range(0, 4) == 0);
            lgl   = m_legal(tr, a, sz, 1'b0);
            tick(); addr_phase(tr, a, w, sz, HBURST_INCR);
            tick(); trans = HTRANS_IDLE; wdata = wd;
            if (lgl) begin
                for (int k = 0; k <= waits; k++) begin
                    if (k > 0) tick();
                    oready = (k == waits); oerr = err && (k == waits); ordata = $urandom;
                    @(negedge clk);
                    n_checks++;
                    if (loc_obs !== {a, w, sz, m_strb(a, sz), wd, 4'd0})
                        $display("FAIL rnd_local[%0d.%0d]: got %h expected %h", n, k, loc_obs,
                                 {a, w, sz, m_strb(a, sz), wd, 4'd0});
                    else n_pass++;
                    n_checks++;
                    if (hs_obs !== {(k == waits) && !err, 1'b0, 1'b1} ||
                        rdata !== ((k == waits) ? ordata : '0))
                        $display("FAIL rnd_hs[%0d.%0d]: got hs=%b rdata=%h expected ready=%0d rdata=%h",
                                 n, k, hs_obs, rdata, (k == waits) && !err, (k == waits) ? ordata : '0);
                    else n_pass++;
                end
                tick(); oready = 1'b0; oerr = 1'b0;
            end
            if (!lgl || err) begin
                @(negedge clk);
                n_checks++;
                if (hs_obs !== 3'b010) $display("FAIL rnd_err1[%0d]: got %b expected 010", n, hs_obs);
                else n_pass++;
                tick();
                @(negedge clk);
                n_checks++;
                if (hs_obs !== 3'b110) $display("FAIL rnd_err2[%0d]: got %b expected 110", n, hs_obs);
                else n_pass++;
                tick();
            end
            @(negedge clk);
            n_checks++;
            if (hs_obs !== 3'b100 || loc_obs !== '0)
                $display("FAIL rnd_idle[%0d]: got hs=%b loc=%h expected 100/0", n, hs_obs, loc_obs);
            else n_pass++;
        end
    endtask

`ifdef AHB_WSTRB_EN
    task automatic test_wstrb();
        tick(); addr_phase(HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2, HBURST_SINGLE);
        tick(); trans = HTRANS_IDLE; hstrb = 4'h5; oready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ostrb !== 4'h5 || hs_obs !== 3'b101)
            $display("FAIL wstrb_mask: got strb=%h hs=%b expected 5/101", ostrb, hs_obs);
        else n_pass++;
        tick(); addr_phase(HTRANS_NONSEQ, 32'h14, 1'b1, 3'd2, HBURST_SINGLE); hstrb = '1; oready = 1'b0;
        tick(); trans = HTRANS_IDLE; hstrb = '0;
        @(negedge clk);
        n_checks++;
        if (hs_obs !== 3'b100 || loc_obs !== '0)
            $display("FAIL wstrb_null: got hs=%b loc=%h expected 100/0", hs_obs, loc_obs);
        else n_pass++;
        tick(); hstrb = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_incr4();
        test_misaligned();
        test_slave_error();
        test_reset_mid_access();
        test_random();
`ifdef AHB_WSTRB_EN
        test_wstrb();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
